lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the small decode helpers used by both the controller and the aligner.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    // True when the access cannot be performed at this byte offset (or size is illegal).
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane enables of a store within the addressed word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: picks and extends the load lane out of a
// memory word, and merges right-aligned store data into an old word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [7:0]  rd_lane [4];
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        sign_bit;
    logic [3:0]  store_mask;
    logic [31:0] store_repl;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_lane[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_byte   = rd_lane[addr_lo_i];
        lane_half   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_bit    = 1'b0;
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                sign_bit    = ~unsigned_i & lane_byte[7];
                load_data_o = {{24{sign_bit}}, lane_byte};
            end
            SZ_HALF: begin
                sign_bit    = ~unsigned_i & lane_half[15];
                load_data_o = {{16{sign_bit}}, lane_half};
            end
            default: load_data_o = rdata_i;
        endcase
    end

    // Replicate the store data across the word so every enabled lane sees its bytes.
    always_comb begin
        store_mask = lane_mask(size_i, addr_lo_i);
        case (size_i)
            SZ_BYTE: store_repl = {4{wdata_i[7:0]}};
            SZ_HALF: store_repl = {2{wdata_i[15:0]}};
            default: store_repl = wdata_i;
        endcase
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word_o[8*gi +: 8] = store_mask[gi] ? store_repl[8*gi +: 8]
                                                              : old_word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, performs the word
// access (read-modify-write for sub-word stores) and returns a one-cycle response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic        idle_ready;
    logic        range_err;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic [31:0] word_addr;

    // rst_n is active-high despite its name; ready is masked while it is asserted.
    assign req_ready = idle_ready & ~rst_n;
    assign range_err = ((req_addr >> ADDR_W) != 32'd0);
    assign req_err   = range_err | misaligned(req_size, req_addr[1:0]);
    assign word_addr = {addr_q[31:2], 2'b00};

    lsu_align u_align (
        .size_i        (size_q),
        .addr_lo_i     (addr_q[1:0]),
        .unsigned_i    (uns_q),
        .rdata_i       (mem_rdata),
        .old_word_i    (data_q),
        .wdata_i       (wdata_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        data_d     = data_q;
        idle_ready = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;

        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    data_d  = 32'd0;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_addr = word_addr;
                // Stores keep the raw old word for merging; loads keep the extended lane.
                data_d   = we_q ? mem_rdata : load_data;
                state_d  = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = merged_word;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'd0 : data_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
